// File: rtl/sfm_batch_ctrl.sv
// Multi-row softmax batch sequencer.
// Per row: max/accumulate pass, reciprocal, optional divide pass, then a
// datapath clear. One done_o at batch end and one evt_row_o per row.
// Optional feature: define SFM_BATCH_CTRL_PERF_EN to add a saturating busy
// cycle counter on perf_cycles_o.
module sfm_batch_ctrl #(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ROW_CNT_W  = 16,
    parameter int unsigned LEN_W      = 24
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] cfg_in_addr_i,
    input  logic [ADDR_WIDTH-1:0] cfg_out_addr_i,
    input  logic [ADDR_WIDTH-1:0] cfg_row_stride_i,
    input  logic [LEN_W-1:0]      cfg_tot_len_i,
    input  logic [ROW_CNT_W-1:0]  cfg_n_rows_i,
    input  logic                  cfg_acc_only_i,
    input  logic                  in_done_i,
    input  logic                  out_done_i,
    input  logic                  dp_busy_i,
    input  logic                  acc_done_i,
    input  logic                  inv_done_i,
    output logic                  in_start_o,
    output logic                  out_start_o,
    output logic [ADDR_WIDTH-1:0] in_base_addr_o,
    output logic [ADDR_WIDTH-1:0] out_base_addr_o,
    output logic [LEN_W-1:0]      tot_beats_o,
    output logic                  dp_acc_finished_o,
    output logic                  dp_dividing_o,
    output logic                  dp_disable_max_o,
    output logic                  clear_regs_o,
    output logic [ROW_CNT_W-1:0]  row_idx_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  evt_row_o
`ifdef SFM_BATCH_CTRL_PERF_EN
    ,
    output logic [31:0]           perf_cycles_o
`endif
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned SHIFT = $clog2(BYTES);

    typedef enum logic [2:0] {
        StIdle,
        StAcc,
        StWaitEmpty,
        StWaitAcc,
        StWaitInv,
        StDivide,
        StRowDone,
        StFinished
    } state_e;

    state_e                state_q, state_d;
    logic                  in_start_q, in_start_d;
    logic                  out_start_q, out_start_d;
    logic [ADDR_WIDTH-1:0] in_addr_q, out_addr_q, stride_q;
    logic [LEN_W-1:0]      beats_q;
    logic [ROW_CNT_W-1:0]  n_rows_q, row_idx_q;
    logic                  acc_only_q;
    logic                  accept, row_adv, last_row;
    logic [LEN_W-1:0]      beats_calc;

    // Round the byte length up to whole bus beats.
    assign beats_calc = (cfg_tot_len_i >> SHIFT) + LEN_W'(|cfg_tot_len_i[SHIFT-1:0]);
    assign last_row   = (row_idx_q == n_rows_q - ROW_CNT_W'(1));

    // Next-state logic and registered start-pulse requests.
    always_comb begin
        state_d     = state_q;
        in_start_d  = 1'b0;
        out_start_d = 1'b0;
        accept      = 1'b0;
        row_adv     = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    accept = 1'b1;
                    if (cfg_n_rows_i == '0 || cfg_tot_len_i == '0) begin
                        state_d = StFinished;
                    end else begin
                        state_d    = StAcc;
                        in_start_d = 1'b1;
                    end
                end
            end
            StAcc:       if (in_done_i) state_d = StWaitEmpty;
            StWaitEmpty: if (!dp_busy_i) state_d = StWaitAcc;
            StWaitAcc: begin
                if (acc_done_i) begin
                    state_d = StWaitInv;
                    // Divide pass re-reads the row and writes the result.
                    if (!acc_only_q) begin
                        in_start_d  = 1'b1;
                        out_start_d = 1'b1;
                    end
                end
            end
            StWaitInv:   if (inv_done_i) state_d = acc_only_q ? StRowDone : StDivide;
            StDivide:    if (out_done_i) state_d = StRowDone;
            StRowDone: begin
                row_adv = 1'b1;
                if (last_row) begin
                    state_d = StFinished;
                end else begin
                    state_d    = StAcc;
                    in_start_d = 1'b1;
                end
            end
            StFinished:  state_d = StIdle;
            default:     state_d = StIdle;
        endcase
    end

    // State, configuration and per-row address registers; clear_i wins over everything.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            in_start_q  <= 1'b0;
            out_start_q <= 1'b0;
            in_addr_q   <= '0;
            out_addr_q  <= '0;
            stride_q    <= '0;
            beats_q     <= '0;
            n_rows_q    <= '0;
            row_idx_q   <= '0;
            acc_only_q  <= 1'b0;
        end else if (clear_i) begin
            state_q     <= StIdle;
            in_start_q  <= 1'b0;
            out_start_q <= 1'b0;
            in_addr_q   <= '0;
            out_addr_q  <= '0;
            stride_q    <= '0;
            beats_q     <= '0;
            n_rows_q    <= '0;
            row_idx_q   <= '0;
            acc_only_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_start_q  <= in_start_d;
            out_start_q <= out_start_d;
            if (accept) begin
                in_addr_q  <= cfg_in_addr_i;
                out_addr_q <= cfg_out_addr_i;
                stride_q   <= cfg_row_stride_i;
                beats_q    <= beats_calc;
                n_rows_q   <= cfg_n_rows_i;
                row_idx_q  <= '0;
                acc_only_q <= cfg_acc_only_i;
            end else if (row_adv) begin
                in_addr_q  <= in_addr_q + stride_q;
                out_addr_q <= out_addr_q + stride_q;
                row_idx_q  <= row_idx_q + ROW_CNT_W'(1);
            end
        end
    end

    // Datapath controls and status decoded from the current state.
    always_comb begin
        dp_acc_finished_o = 1'b0;
        dp_dividing_o     = 1'b0;
        dp_disable_max_o  = 1'b0;
        case (state_q)
            StWaitEmpty: dp_acc_finished_o = !dp_busy_i;
            StWaitAcc: begin
                // Dropped while the divide pass is being launched.
                dp_acc_finished_o = !(acc_done_i && !acc_only_q);
                dp_disable_max_o  = 1'b1;
            end
            StWaitInv, StDivide: begin
                dp_dividing_o    = 1'b1;
                dp_disable_max_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign in_start_o      = in_start_q;
    assign out_start_o     = out_start_q;
    assign in_base_addr_o  = in_addr_q;
    assign out_base_addr_o = out_addr_q;
    assign tot_beats_o     = beats_q;
    assign row_idx_o       = row_idx_q;
    assign clear_regs_o    = (state_q == StRowDone);
    assign evt_row_o       = (state_q == StRowDone);
    assign done_o          = (state_q == StFinished);
    assign busy_o          = (state_q != StIdle) && (state_q != StFinished);

`ifdef SFM_BATCH_CTRL_PERF_EN
    logic [31:0] perf_q;

    // Busy-cycle counter: zeroed on accept, saturates, holds between jobs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_q <= '0;
        end else if (clear_i) begin
            perf_q <= '0;
        end else if (accept) begin
            perf_q <= '0;
        end else if (busy_o && perf_q != 32'hFFFF_FFFF) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles_o = perf_q;
`endif

endmodule

// File: tb/tb_sfm_batch_ctrl.sv
// Self-checking bench for sfm_batch_ctrl: directed and randomized batch jobs
// checked against expected addresses, beat counts and pulse counts.
module tb_sfm_batch_ctrl;

    localparam int unsigned DW    = 256;
    localparam int unsigned AW    = 32;
    localparam int unsigned RW    = 16;
    localparam int unsigned LW    = 24;
    localparam int unsigned BYTES = DW / 8;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          clear_i = 1'b0;
    logic          start_i = 1'b0;
    logic [AW-1:0] cfg_in_addr_i = '0;
    logic [AW-1:0] cfg_out_addr_i = '0;
    logic [AW-1:0] cfg_row_stride_i = '0;
    logic [LW-1:0] cfg_tot_len_i = '0;
    logic [RW-1:0] cfg_n_rows_i = '0;
    logic          cfg_acc_only_i = 1'b0;
    logic          in_done_i = 1'b0;
    logic          out_done_i = 1'b0;
    logic          dp_busy_i = 1'b0;
    logic          acc_done_i = 1'b0;
    logic          inv_done_i = 1'b0;
    logic          in_start_o, out_start_o;
    logic [AW-1:0] in_base_addr_o, out_base_addr_o;
    logic [LW-1:0] tot_beats_o;
    logic          dp_acc_finished_o, dp_dividing_o, dp_disable_max_o, clear_regs_o;
    logic [RW-1:0] row_idx_o;
    logic          busy_o, done_o, evt_row_o;
`ifdef SFM_BATCH_CTRL_PERF_EN
    logic [31:0]   perf_cycles_o;
`endif

    sfm_batch_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .ROW_CNT_W (RW),
        .LEN_W     (LW)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .clear_i          (clear_i),
        .start_i          (start_i),
        .cfg_in_addr_i    (cfg_in_addr_i),
        .cfg_out_addr_i   (cfg_out_addr_i),
        .cfg_row_stride_i (cfg_row_stride_i),
        .cfg_tot_len_i    (cfg_tot_len_i),
        .cfg_n_rows_i     (cfg_n_rows_i),
        .cfg_acc_only_i   (cfg_acc_only_i),
        .in_done_i        (in_done_i),
        .out_done_i       (out_done_i),
        .dp_busy_i        (dp_busy_i),
        .acc_done_i       (acc_done_i),
        .inv_done_i       (inv_done_i),
        .in_start_o       (in_start_o),
        .out_start_o      (out_start_o),
        .in_base_addr_o   (in_base_addr_o),
        .out_base_addr_o  (out_base_addr_o),
        .tot_beats_o      (tot_beats_o),
        .dp_acc_finished_o(dp_acc_finished_o),
        .dp_dividing_o    (dp_dividing_o),
        .dp_disable_max_o (dp_disable_max_o),
        .clear_regs_o     (clear_regs_o),
        .row_idx_o        (row_idx_o),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .evt_row_o        (evt_row_o)
`ifdef SFM_BATCH_CTRL_PERF_EN
        ,
        .perf_cycles_o    (perf_cycles_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_pass = 0;
    int n_in   = 0;
    int n_out  = 0;
    int n_done = 0;
    int n_evt  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock; sample outputs on the falling edge and count pulses.
    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
        if (in_start_o === 1'b1) n_in++;
        if (out_start_o === 1'b1) n_out++;
        if (done_o === 1'b1) n_done++;
        if (evt_row_o === 1'b1) n_evt++;
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return in_start_o === 1'b1;
            1:       return (dp_acc_finished_o & dp_disable_max_o) === 1'b1;
            2:       return dp_dividing_o === 1'b1;
            3:       return evt_row_o === 1'b1;
            default: return done_o === 1'b1;
        endcase
    endfunction

    task automatic wait_for(input int which, input string tag);
        int k = 0;
        while (!sig(which) && k < 40) begin
            step();
            k++;
        end
        if (!sig(which)) chk({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic scramble_cfg();
        cfg_in_addr_i    = $urandom;
        cfg_out_addr_i   = $urandom;
        cfg_row_stride_i = $urandom;
        cfg_tot_len_i    = LW'($urandom);
        cfg_n_rows_i     = RW'($urandom_range(0, 9));
        cfg_acc_only_i   = 1'($urandom);
    endtask

    // One batch job acting as streamers and datapath; clr_row >= 0 aborts that
    // row with clear_i once its divide pass is running.
    task automatic run_job(input int n, input int len, input logic [AW-1:0] ia,
                           input logic [AW-1:0] oa, input logic [AW-1:0] st,
                           input bit ao, input int clr_row);
        int          i0 = n_in;
        int          o0 = n_out;
        int          d0 = n_done;
        int          e0 = n_evt;
        int          exp_beats = (len + BYTES - 1) / BYTES;
        logic [63:0] exp_in, exp_out;
        cfg_in_addr_i    = ia;
        cfg_out_addr_i   = oa;
        cfg_row_stride_i = st;
        cfg_tot_len_i    = LW'(len);
        cfg_n_rows_i     = RW'(n);
        cfg_acc_only_i   = ao;
        start_i          = 1'b1;
        step();
        start_i = 1'b0;
        scramble_cfg();
        if (n == 0 || len == 0) begin
            wait_for(4, "deg_done");
            chk("deg_busy_at_done", 64'(busy_o), 64'd0);
            chk("deg_in_starts", 64'(n_in - i0), 64'd0);
            step();
            step();
            chk("deg_done_count", 64'(n_done - d0), 64'd1);
            chk("deg_out_starts", 64'(n_out - o0), 64'd0);
            return;
        end
        for (int r = 0; r < n; r++) begin
            exp_in  = (64'(ia) + 64'(r) * 64'(st)) & 64'hFFFF_FFFF;
            exp_out = (64'(oa) + 64'(r) * 64'(st)) & 64'hFFFF_FFFF;
            wait_for(0, "acc_start");
            chk("in_base", 64'(in_base_addr_o), exp_in);
            chk("out_base", 64'(out_base_addr_o), exp_out);
            chk("row_idx", 64'(row_idx_o), 64'(r));
            chk("tot_beats", 64'(tot_beats_o), 64'(exp_beats));
            chk("busy_in_row", 64'(busy_o), 64'd1);
            // A start while busy must be ignored.
            start_i = 1'b1;
            step();
            start_i = 1'b0;
            scramble_cfg();
            repeat ($urandom_range(0, 2)) step();
            dp_busy_i = 1'b1;
            in_done_i = 1'b1;
            step();
            in_done_i = 1'b0;
            repeat ($urandom_range(0, 3)) step();
            dp_busy_i = 1'b0;
            wait_for(1, "acc_ready");
            repeat ($urandom_range(0, 2)) step();
            acc_done_i = 1'b1;
            step();
            acc_done_i = 1'b0;
            chk("div_in_start", 64'(in_start_o), 64'(!ao));
            chk("div_out_start", 64'(out_start_o), 64'(!ao));
            chk("dividing_after_acc", 64'(dp_dividing_o), 64'd1);
            wait_for(2, "inv_wait");
            repeat ($urandom_range(0, 2)) step();
            inv_done_i = 1'b1;
            step();
            inv_done_i = 1'b0;
            if (!ao) begin
                if (r == clr_row) begin
                    clear_i = 1'b1;
                    step();
                    clear_i = 1'b0;
                    chk("clr_busy", 64'(busy_o), 64'd0);
                    chk("clr_in_base", 64'(in_base_addr_o), 64'd0);
                    chk("clr_row_idx", 64'(row_idx_o), 64'd0);
                    chk("clr_beats", 64'(tot_beats_o), 64'd0);
                    repeat (4) step();
                    chk("clr_no_done", 64'(n_done - d0), 64'd0);
                    chk("clr_idle_busy", 64'(busy_o), 64'd0);
                    return;
                end
                repeat ($urandom_range(0, 2)) step();
                out_done_i = 1'b1;
                step();
                out_done_i = 1'b0;
            end
            wait_for(3, "row_evt");
            chk("evt_count", 64'(n_evt - e0), 64'(r + 1));
        end
        wait_for(4, "done");
        chk("busy_at_done", 64'(busy_o), 64'd0);
        step();
        chk("in_start_count", 64'(n_in - i0), 64'(ao ? n : 2 * n));
        chk("out_start_count", 64'(n_out - o0), 64'(ao ? 0 : n));
        chk("evt_total", 64'(n_evt - e0), 64'(n));
        chk("done_count", 64'(n_done - d0), 64'd1);
        chk("idle_after_done", 64'(busy_o), 64'd0);
    endtask

    initial begin
        #12;
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_in_start", 64'(in_start_o), 64'd0);
        chk("rst_in_base", 64'(in_base_addr_o), 64'd0);
        chk("rst_beats", 64'(tot_beats_o), 64'd0);
        chk("rst_row_idx", 64'(row_idx_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();

        run_job(1, 64, 32'h0000_4000, 32'h0000_8000, 32'h40, 1'b0, -1);
        step();
        run_job(1, 65, 32'h10, 32'h20, 32'h0, 1'b0, -1);
        step();
        run_job(1, 32, 32'h10, 32'h20, 32'h0, 1'b0, -1);
        step();
        run_job(3, 96, 32'h1000, 32'h2000, 32'h100, 1'b0, -1);
        step();
        run_job(2, 40, 32'h3000, 32'h5000, 32'h80, 1'b1, -1);
        step();
        run_job(0, 64, 32'h1000, 32'h2000, 32'h100, 1'b0, -1);
        step();
        run_job(2, 0, 32'h1000, 32'h2000, 32'h100, 1'b0, -1);
        step();
        run_job(3, 128, 32'h1000, 32'h2000, 32'h100, 1'b0, 1);
        step();
        run_job(2, 33, 32'h1000, 32'h2000, 32'h100, 1'b0, -1);
        step();
        run_job(3, 17, 32'hFFFF_FF80, 32'hFFFF_FFF0, 32'h100, 1'b0, -1);
        for (int j = 0; j < 6; j++) begin
            step();
            run_job(int'($urandom_range(1, 4)), int'($urandom_range(1, 300)), $urandom,
                    $urandom, $urandom, 1'($urandom), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
